ctrl_pipe_exc: RTL

Parametrised control-word pipeline with precise exception sequencing for the pipelined MIPS core. It takes the decoded control bundle from decode and carries it through NSTAGE stage registers (E, M, W by default) with per-stage stall and flush. At a configurable commit stage it turns invalid opcodes, external interrupts and `rti` into one-cycle PC redirects, and it holds EPC, cause and the handler/run state. It replaces the fixed-width hand-packed stage registers in the controller.

---
 rtl/ctrl_pipe_exc.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/ctrl_pipe_exc.sv
// ctrl_pipe_exc: control-word pipeline (NSTAGE stage registers after decode,
// stage 0 = E) with per-stage stall/flush and precise exception sequencing
// at stage EXC_STAGE: invalid opcodes, external interrupts and rti become
// one-cycle PC redirects; EPC, cause and the RUN/HANDLER state live here.
// Optional feature macro: CTRL_PIPE_IRQ_EN (interrupt latch and cause=2).
module ctrl_pipe_exc #(
    parameter int          CW        = 36,
    parameter int          NSTAGE    = 3,
    parameter int          EXC_STAGE = 1,
    parameter logic [31:0] VEC       = 32'h0000_0180
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [CW-1:0]        ctrl_d,
    input  logic                 valid_d,
    input  logic [31:0]          pc_d,
    input  logic                 invalid_d,
    input  logic                 rti_d,
    input  logic                 irq,
    input  logic [NSTAGE-1:0]    stall,
    input  logic [NSTAGE-1:0]    flush,
    output logic [NSTAGE*CW-1:0] ctrl_q,
    output logic [NSTAGE-1:0]    valid_q,
    output logic                 redir,
    output logic [31:0]          redir_pc,
    output logic [31:0]          epc,
    output logic [1:0]           cause,
    output logic                 in_handler
);

    typedef enum logic {
        RUN     = 1'b0,
        HANDLER = 1'b1
    } state_t;

    state_t      state_reg;
    logic        redir_reg;
    logic [31:0] redir_pc_reg;
    logic [31:0] epc_reg;
    logic [1:0]  cause_reg;
    logic        pending;

    // Flattened view of every stage so neighbours and the commit logic can
    // read them without reaching into generate scopes.
    logic [NSTAGE-1:0] valid_vec;
    logic [NSTAGE-1:0] inv_vec;
    logic [NSTAGE-1:0] rti_vec;
    logic [31:0]       pc_vec [NSTAGE];

    logic eval_ok;
    logic ev_invalid;
    logic ev_return;
    logic ev_irq;
    logic ev_any;

    // Classify the instruction sitting in the commit stage; invalid beats
    // rti beats interrupt, and rti outside the handler counts as invalid.
    always_comb begin
        eval_ok    = valid_vec[EXC_STAGE] && !stall[EXC_STAGE];
        ev_invalid = eval_ok && (inv_vec[EXC_STAGE] ||
                                 (rti_vec[EXC_STAGE] && state_reg == RUN));
        ev_return  = eval_ok && !inv_vec[EXC_STAGE] && rti_vec[EXC_STAGE] &&
                     state_reg == HANDLER;
        ev_irq     = eval_ok && !inv_vec[EXC_STAGE] && !rti_vec[EXC_STAGE] &&
                     pending && state_reg == RUN;
        ev_any     = ev_invalid || ev_return || ev_irq;
    end

    genvar gi;
    generate
        for (gi = 0; gi < NSTAGE; gi++) begin : g_stage
            // Stages up to the commit stage are squashed by an event; the
            // one right after it takes a bubble so the event never commits.
            localparam bit SQUASH_EN = (gi <= EXC_STAGE + 1);

            logic [CW-1:0] ctrl_reg;
            logic          valid_reg;
            logic [31:0]   pc_reg;
            logic          inv_reg;
            logic          rti_reg;

            logic [CW-1:0] ctrl_in;
            logic          valid_in;
            logic [31:0]   pc_in;
            logic          inv_in;
            logic          rti_in;

            if (gi == 0) begin : g_src_decode
                assign ctrl_in  = ctrl_d;
                assign valid_in = valid_d;
                assign pc_in    = pc_d;
                assign inv_in   = invalid_d;
                assign rti_in   = rti_d;
            end else begin : g_src_prev
                assign ctrl_in  = g_stage[gi-1].ctrl_reg;
                assign valid_in = valid_vec[gi-1];
                assign pc_in    = pc_vec[gi-1];
                assign inv_in   = inv_vec[gi-1];
                assign rti_in   = rti_vec[gi-1];
            end

            // Stage register: stall holds (and masks flush/squash), flush or
            // squash clears, otherwise advance from the previous stage.
            always_ff @(posedge clk) begin
                if (reset) begin
                    ctrl_reg  <= '0;
                    valid_reg <= 1'b0;
                    pc_reg    <= '0;
                    inv_reg   <= 1'b0;
                    rti_reg   <= 1'b0;
                end else if (stall[gi]) begin
                    ctrl_reg  <= ctrl_reg;
                    valid_reg <= valid_reg;
                    pc_reg    <= pc_reg;
                    inv_reg   <= inv_reg;
                    rti_reg   <= rti_reg;
                end else if (flush[gi] || (SQUASH_EN && ev_any)) begin
                    ctrl_reg  <= '0;
                    valid_reg <= 1'b0;
                    pc_reg    <= '0;
                    inv_reg   <= 1'b0;
                    rti_reg   <= 1'b0;
                end else begin
                    ctrl_reg  <= ctrl_in;
                    valid_reg <= valid_in;
                    pc_reg    <= pc_in;
                    inv_reg   <= inv_in;
                    rti_reg   <= rti_in;
                end
            end

            assign valid_vec[gi]          = valid_reg;
            assign inv_vec[gi]            = inv_reg;
            assign rti_vec[gi]            = rti_reg;
            assign pc_vec[gi]             = pc_reg;
            assign ctrl_q[gi*CW +: CW]    = ctrl_reg;
            assign valid_q[gi]            = valid_reg;
        end
    endgenerate

`ifdef CTRL_PIPE_IRQ_EN
    logic pending_reg;
    assign pending = pending_reg;
`else
    assign pending = 1'b0;
`endif

    // Exception FSM: redirect pulse, target, EPC/cause and RUN/HANDLER.
    // The pending latch is cleared by the interrupt it causes, which takes
    // precedence over a fresh irq seen on the same edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= RUN;
            redir_reg    <= 1'b0;
            redir_pc_reg <= '0;
            epc_reg      <= '0;
            cause_reg    <= 2'd0;
`ifdef CTRL_PIPE_IRQ_EN
            pending_reg  <= 1'b0;
`endif
        end else begin
            redir_reg <= ev_any;
            if (ev_invalid) begin
                epc_reg      <= pc_vec[EXC_STAGE];
                cause_reg    <= 2'd1;
                state_reg    <= HANDLER;
                redir_pc_reg <= VEC;
            end else if (ev_return) begin
                state_reg    <= RUN;
                redir_pc_reg <= epc_reg;
            end
`ifdef CTRL_PIPE_IRQ_EN
            else if (ev_irq) begin
                epc_reg      <= pc_vec[EXC_STAGE];
                cause_reg    <= 2'd2;
                state_reg    <= HANDLER;
                redir_pc_reg <= VEC;
            end
            if (ev_irq) begin
                pending_reg <= 1'b0;
            end else if (irq && state_reg == RUN) begin
                pending_reg <= 1'b1;
            end
`endif
        end
    end

    assign redir      = redir_reg;
    assign redir_pc   = redir_pc_reg;
    assign epc        = epc_reg;
    assign cause      = cause_reg;
    assign in_handler = (state_reg == HANDLER);

    // Last-stage side fields have no consumer, and irq is unused when the
    // interrupt feature is compiled out.
    logic unused_bits;
    assign unused_bits = ^{irq, pc_vec[NSTAGE-1], inv_vec[NSTAGE-1], rti_vec[NSTAGE-1]};

endmodule
